// File: rtl/sd_spi_data_check.sv
// Checks each sector read from the SD card against the pattern (seed + index) mod 256.
// Optional CRC16-CCITT trailer check is enabled by defining SD_CHECK_CRC16_EN.
module sd_spi_data_check #(
  parameter int unsigned BLOCK_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rd_start,
  input  logic [31:0] sector_addr,
  input  logic        rd_data_valid,
  input  logic [7:0]  rd_data,
  input  logic        rd_done,
  output logic        error_flag,
  output logic        check_busy,
  output logic [15:0] err_count,
  output logic [15:0] blocks_ok
);

  localparam int unsigned CNT_W = $clog2(BLOCK_BYTES + 1);

`ifdef SD_CHECK_CRC16_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, REPORT = 2'd2, CRC = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, REPORT = 2'd2} state_e;
`endif

  state_e             state_q, state_d;
  logic [7:0]         seed_q, seed_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic               block_err_q, block_err_d;
  logic               error_flag_q, error_flag_d;
  logic [15:0]        err_count_q, err_count_d;
  logic [15:0]        blocks_ok_q, blocks_ok_d;
  logic               last_byte;
  logic [7:0]         expected;
  logic               unused_addr_hi;

`ifdef SD_CHECK_CRC16_EN
  logic [15:0]        crc_q, crc_d;
  logic               crc_idx_q, crc_idx_d;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int unsigned k = 0; k < 8; k++) begin
      fb = c[15] ^ data[7-k];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction
`endif

  assign unused_addr_hi = ^sector_addr[31:8];
  assign last_byte      = rd_data_valid && (byte_cnt_q == CNT_W'(BLOCK_BYTES - 1));
  assign expected       = seed_q + 8'(byte_cnt_q);

  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    byte_cnt_d   = byte_cnt_q;
    block_err_d  = block_err_q;
    error_flag_d = 1'b0;
    err_count_d  = err_count_q;
    blocks_ok_d  = blocks_ok_q;
`ifdef SD_CHECK_CRC16_EN
    crc_d        = crc_q;
    crc_idx_d    = crc_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (rd_start) begin
          seed_d      = sector_addr[7:0];
          byte_cnt_d  = '0;
          block_err_d = 1'b0;
`ifdef SD_CHECK_CRC16_EN
          crc_d       = '0;
          crc_idx_d   = 1'b0;
`endif
          state_d     = DATA;
        end
      end
      DATA: begin
        if (rd_data_valid) begin
          if (rd_data != expected) block_err_d = 1'b1;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
`ifdef SD_CHECK_CRC16_EN
          crc_d      = crc16_byte(crc_q, rd_data);
`endif
        end
`ifdef SD_CHECK_CRC16_EN
        // With the trailer enabled, rd_done on the last data byte still leaves the CRC missing.
        if (rd_done) begin
          block_err_d = 1'b1;
          state_d     = REPORT;
        end else if (last_byte) begin
          state_d = CRC;
        end
`else
        if (last_byte) begin
          state_d = REPORT;
        end else if (rd_done) begin
          block_err_d = 1'b1;
          state_d     = REPORT;
        end
`endif
      end
`ifdef SD_CHECK_CRC16_EN
      CRC: begin
        if (rd_data_valid) begin
          if (!crc_idx_q) begin
            if (rd_data != crc_q[15:8]) block_err_d = 1'b1;
            crc_idx_d = 1'b1;
          end else begin
            if (rd_data != crc_q[7:0]) block_err_d = 1'b1;
            state_d = REPORT;
          end
        end
        if (rd_done && !(rd_data_valid && crc_idx_q)) begin
          block_err_d = 1'b1;
          state_d     = REPORT;
        end
      end
`endif
      REPORT: begin
        error_flag_d = block_err_q;
        if (block_err_q) begin
          err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
        end else begin
          blocks_ok_d = (blocks_ok_q == 16'hFFFF) ? blocks_ok_q : blocks_ok_q + 16'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      seed_q       <= '0;
      byte_cnt_q   <= '0;
      block_err_q  <= 1'b0;
      error_flag_q <= 1'b0;
      err_count_q  <= '0;
      blocks_ok_q  <= '0;
`ifdef SD_CHECK_CRC16_EN
      crc_q        <= '0;
      crc_idx_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      byte_cnt_q   <= byte_cnt_d;
      block_err_q  <= block_err_d;
      error_flag_q <= error_flag_d;
      err_count_q  <= err_count_d;
      blocks_ok_q  <= blocks_ok_d;
`ifdef SD_CHECK_CRC16_EN
      crc_q        <= crc_d;
      crc_idx_q    <= crc_idx_d;
`endif
    end
  end

  assign error_flag = error_flag_q;
  assign check_busy = (state_q != IDLE);
  assign err_count  = err_count_q;
  assign blocks_ok  = blocks_ok_q;

endmodule

// File: tb/tb_sd_spi_data_check.sv
// Self-checking bench for sd_spi_data_check: directed vector table, random sectors
// against a sector-level reference model, reset and saturation sequences.
module tb_sd_spi_data_check;

  localparam int BB = 512;
`ifdef SD_CHECK_CRC16_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_start;
  logic [31:0] sector_addr;
  logic        rd_data_valid;
  logic [7:0]  rd_data;
  logic        rd_done;
  logic        error_flag;
  logic        check_busy;
  logic [15:0] err_count;
  logic [15:0] blocks_ok;

  int checks = 0;
  int errors = 0;
  int model_err = 0;
  int model_ok  = 0;

  sd_spi_data_check #(.BLOCK_BYTES(BB)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rd_start      (rd_start),
    .sector_addr   (sector_addr),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .rd_done       (rd_done),
    .error_flag    (error_flag),
    .check_busy    (check_busy),
    .err_count     (err_count),
    .blocks_ok     (blocks_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    int          n;
    int          cidx;
    logic [7:0]  cval;
    bit          done_last;
    logic [7:0]  crc_flip;
    bit          exp_err;
    string       tag;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  function automatic logic [15:0] crc_of(input logic [7:0] q[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    foreach (q[j]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ q[j][k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  // Drive one sector; exp_in < 0 means the reference model decides pass/fail.
  task automatic run_sector(input logic [31:0] addr, input int n, input int cidx,
                            input logic [7:0] cval, input bit done_last,
                            input logic [7:0] crc_flip, input bit gaps, input bit poke,
                            input int exp_in, input string tag);
    logic [7:0]  q[$];
    logic [7:0]  b;
    logic [15:0] crc;
    bit          spur;
    bit          bad;
    bit          exp_err;

    // Junk in IDLE must not start or disturb anything.
    rd_data_valid = 1'b1; rd_data = 8'($urandom); rd_done = 1'b1;
    @(negedge clk);
    rd_data_valid = 1'b0; rd_done = 1'b0;
    rd_start = 1'b1; sector_addr = addr;
    @(negedge clk);
    rd_start = 1'b0;
    check({tag, " busy after start"}, 32'(check_busy), 32'd1);

    spur = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom % 4 == 0)) begin
        rd_data_valid = 1'b0; rd_done = 1'b0;
        @(negedge clk);
        spur |= error_flag;
      end
      b = addr[7:0] + 8'(i);
      if (i == cidx) b = cval;
      q.push_back(b);
      rd_data_valid = 1'b1; rd_data = b;
      rd_done = (i == n - 1) && done_last && ((n < BB) || !CRC_EN);
      if (poke && i == 3) begin
        rd_start = 1'b1; sector_addr = $urandom;
      end
      @(negedge clk);
      spur |= error_flag;
      rd_start = 1'b0;
    end

    crc = crc_of(q);
    if (CRC_EN && n == BB) begin
      rd_data_valid = 1'b1; rd_data = crc[15:8]; rd_done = 1'b0;
      @(negedge clk);
      spur |= error_flag;
      rd_data = crc[7:0] ^ crc_flip; rd_done = done_last;
      @(negedge clk);
      spur |= error_flag;
    end else if (n < BB && !(done_last && n > 0)) begin
      rd_data_valid = 1'b0; rd_done = 1'b1;
      @(negedge clk);
      spur |= error_flag;
    end

    // Now in the REPORT cycle; a stray byte here must be ignored.
    check({tag, " busy in report"}, 32'(check_busy), 32'd1);
    rd_data_valid = 1'b1; rd_data = 8'($urandom); rd_done = 1'b0;
    @(negedge clk);
    rd_data_valid = 1'b0;

    bad = (n < BB);
    foreach (q[j]) if (int'(q[j]) != ((int'(addr[7:0]) + j) % 256)) bad = 1'b1;
    if (CRC_EN && n == BB && crc_flip != 8'h00) bad = 1'b1;
    exp_err = (exp_in >= 0) ? (exp_in != 0) : bad;
    if (exp_err) model_err = sat_inc(model_err);
    else         model_ok  = sat_inc(model_ok);

    check({tag, " no early pulse"}, 32'(spur), 32'd0);
    check({tag, " error_flag"}, 32'(error_flag), 32'(exp_err));
    check({tag, " busy after report"}, 32'(check_busy), 32'd0);
    check({tag, " err_count"}, 32'(err_count), 32'(model_err));
    check({tag, " blocks_ok"}, 32'(blocks_ok), 32'(model_ok));
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    check({tag, " pulse width"}, 32'(error_flag), 32'd0);
  endtask

  initial begin
    vec_t vecs[$];
    bit   spur;
    int   n;
    int   cidx;

    reset_n = 1'b0; rd_start = 1'b0; sector_addr = '0;
    rd_data_valid = 1'b0; rd_data = '0; rd_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset error_flag", 32'(error_flag), 32'd0);
    check("reset check_busy", 32'(check_busy), 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);
    check("reset blocks_ok", 32'(blocks_ok), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    vecs.push_back('{32'h0000_0010, BB,  -1,  8'h00, 1'b0, 8'h00, 1'b0, "good"});
    vecs.push_back('{32'h0000_0010, BB,  100, 8'h00, 1'b0, 8'h00, 1'b1, "byte100"});
    vecs.push_back('{32'h0000_0010, 300, -1,  8'h00, 1'b0, 8'h00, 1'b1, "early300"});
    vecs.push_back('{32'hFFFF_FFF0, BB,  -1,  8'h00, 1'b1, 8'h00, 1'b0, "done_final"});
    vecs.push_back('{32'h1234_56AB, BB,  511, 8'h00, 1'b0, 8'h00, 1'b1, "last_bad"});
    vecs.push_back('{32'h0000_00AB, 511, -1,  8'h00, 1'b1, 8'h00, 1'b1, "done511"});
    vecs.push_back('{32'h0000_0055, 0,   -1,  8'h00, 1'b0, 8'h00, 1'b1, "done_now"});
    vecs.push_back('{32'h0000_0077, BB,  0,   8'h77, 1'b0, 8'h00, 1'b0, "same_val"});
    if (CRC_EN) begin
      vecs.push_back('{32'h0000_0010, BB, -1, 8'h00, 1'b0, 8'h01, 1'b1, "crc_lo_bad"});
      vecs.push_back('{32'h0000_0010, BB, -1, 8'h00, 1'b1, 8'h00, 1'b0, "crc_good"});
    end

    foreach (vecs[v])
      run_sector(vecs[v].addr, vecs[v].n, vecs[v].cidx, vecs[v].cval, vecs[v].done_last,
                 vecs[v].crc_flip, 1'b0, 1'b0, int'(vecs[v].exp_err), vecs[v].tag);

    for (int r = 0; r < 12; r++) begin
      n    = ($urandom % 10 < 7) ? BB : int'($urandom_range(0, BB - 1));
      cidx = ($urandom % 10 < 3) ? int'($urandom_range(0, BB - 1)) : -1;
      run_sector($urandom, n, cidx, 8'($urandom), 1'($urandom),
                 ($urandom % 4 == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 1'b1, 1'b1, -1, $sformatf("rand%0d", r));
    end

    // Reset in the middle of a sector discards it silently.
    rd_start = 1'b1; sector_addr = 32'h10;
    @(negedge clk);
    rd_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      rd_data_valid = 1'b1; rd_data = 8'(16 + i);
      @(negedge clk);
    end
    reset_n = 1'b0; rd_data_valid = 1'b0;
    #1;
    check("midreset error_flag", 32'(error_flag), 32'd0);
    check("midreset check_busy", 32'(check_busy), 32'd0);
    check("midreset err_count", 32'(err_count), 32'd0);
    check("midreset blocks_ok", 32'(blocks_ok), 32'd0);
    model_err = 0; model_ok = 0;
    @(negedge clk);
    reset_n = 1'b1;
    spur = 1'b0;
    repeat (3) begin
      @(negedge clk);
      spur |= error_flag;
    end
    check("midreset no pulse", 32'(spur), 32'd0);
    run_sector(32'h10, BB, -1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0, "after_reset");

    // Preload the failure counter near its ceiling, then push it past.
    force dut.err_count_q = 16'hFFFD;
    @(negedge clk);
    release dut.err_count_q;
    model_err = 16'hFFFD;
    for (int s = 0; s < 4; s++)
      run_sector($urandom, 0, -1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1, $sformatf("sat%0d", s));
    check("sat final err_count", 32'(err_count), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
